// File: rtl/hazard_stall_controller.sv
// Hazard / stall sequencer for a 5-stage RV32IM pipeline.
// Produces the per-register write/flush enables and the EX forwarding
// selects, handling load-use stalls, branch flushes, data-memory busywait
// freezes and multi-cycle DIV/REM holds.
module hazard_stall_controller #(
  parameter int DIV_CYCLES = 34,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_div,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       mem_rd,
  input  logic             mem_we,
  input  logic [4:0]       wb_rd,
  input  logic             wb_we,
  input  logic             branch_taken,
  input  logic             busywait,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DCW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_CYCLES - 1);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] DIV_BUSY   = 2'd2;

  logic [1:0]     state, state_nxt;
  logic [DCW-1:0] div_cnt, div_cnt_nxt;
  logic           load_use;

  // Newest producer wins: EX/MEM before MEM/WB; x0 is hard-wired zero.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_we && mem_rd != 5'd0 && mem_rd == rs)     return 2'b10;
    else if (wb_we && wb_rd != 5'd0 && wb_rd == rs)   return 2'b11;
    else                                              return 2'b00;
  endfunction

  // Load in EX feeding an ID source register that cannot be forwarded in time.
  always_comb
    load_use = ex_memread && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // Prioritised enable/flush decode and next-state selection.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    div_done     = 1'b0;
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    if (RESET) begin
      // outputs stay at their idle values while reset is held
    end else if (busywait) begin
      // memory not ready: freeze everything, drain a bubble into MEM/WB
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (state == DIV_BUSY || (state == RUN && ex_div)) begin
      if (state == DIV_BUSY && div_cnt == DIV_LAST) begin
        div_done    = 1'b1;
        state_nxt   = RUN;
        div_cnt_nxt = '0;
      end else begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
        state_nxt    = DIV_BUSY;
        div_cnt_nxt  = (state == RUN) ? DCW'(1) : div_cnt + DCW'(1);
      end
    end else if (branch_taken) begin
      // the squashed ID instruction cannot cause a load-use stall
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_nxt   = RUN;
    end else if (state == RUN && load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      state_nxt   = LOAD_STALL;
    end else begin
      // LOAD_STALL lasts one cycle; the bubble is now in EX
      state_nxt = RUN;
    end
  end

  // Forwarding selects, independent of stall state.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!RESET) begin
      fwd_a = fwd_sel(ex_rs1);
      fwd_b = fwd_sel(ex_rs2);
    end
  end

  // State and divider hold counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= RUN;
      div_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      stall_count <= '0;
    else if (!pc_write && stall_count != {CNT_W{1'b1}})
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule
